// File: rtl/sdsp_rmw_sequencer.sv
// Read-modify-write sweep that applies SDSP weight updates to N_WORDS consecutive synapse words.
// Each word is read, updated lane by lane, and written back only when some lane changed.
module sdsp_rmw_sequencer #(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned SYN_PER_WORD = 8,
  parameter int unsigned AW           = 13,
  parameter int unsigned N_WORDS      = 32,
  localparam int unsigned DW          = SYN_PER_WORD * (WIDTH + 1),
  localparam int unsigned CW          = $clog2(N_WORDS + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_upd_req,
  input  logic [AW-1:0]           i_upd_base,
  input  logic                    i_upd_v_up,
  input  logic                    i_upd_v_down,
  input  logic                    i_upd_bist,
  output logic                    o_upd_busy,
  output logic                    o_upd_done,
  output logic [CW-1:0]           o_upd_wcount,
  output logic                    o_sram_cs,
  output logic                    o_sram_we,
  output logic [AW-1:0]           o_sram_addr,
  output logic [DW-1:0]           o_sram_wdata,
  input  logic                    i_sram_gnt,
  input  logic [DW-1:0]           i_sram_rdata,
  input  logic [SYN_PER_WORD-1:0] i_pre_act
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StFin} state_t;

  localparam int unsigned LW = WIDTH + 1;

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_wcount;
  logic          r_v_up;
  logic          r_v_down;
  logic          r_bist;

  logic [DW-1:0] w_new_word;
  logic          w_last;

  assign w_last = (r_idx == AW'(N_WORDS - 1));

  // Weight is the low WIDTH bits of a lane; bit WIDTH passes through untouched.
  // In BIST mode each weight drifts toward the rail selected by its own MSB.
  for (genvar gi = 0; gi < SYN_PER_WORD; gi++) begin : g_lane
    logic [WIDTH-1:0] w_wt;
    logic [WIDTH-1:0] w_wt_nxt;
    logic             w_up;
    logic             w_dn;

    assign w_wt = i_sram_rdata[gi*LW +: WIDTH];
    assign w_up = i_pre_act[gi] & (r_bist ? w_wt[WIDTH-1] : r_v_up);
    assign w_dn = i_pre_act[gi] & (r_bist ? ~w_wt[WIDTH-1] : (r_v_down & ~r_v_up));

    assign w_wt_nxt = (w_up && (w_wt != '1)) ? w_wt + 1'b1 :
                      (w_dn && (w_wt != '0)) ? w_wt - 1'b1 : w_wt;

    assign w_new_word[gi*LW +: LW] = {i_sram_rdata[gi*LW + WIDTH], w_wt_nxt};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wcount <= '0;
      r_v_up   <= 1'b0;
      r_v_down <= 1'b0;
      r_bist   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_upd_req) begin
            r_addr   <= i_upd_base;
            r_idx    <= '0;
            r_wcount <= '0;
            r_v_up   <= i_upd_v_up;
            r_v_down <= i_upd_v_down;
            r_bist   <= i_upd_bist;
            r_state  <= StRd;
          end
        end
        StRd: begin
          if (i_sram_gnt) r_state <= StCap;
        end
        StCap: begin
          r_wdata <= w_new_word;
          if (w_new_word != i_sram_rdata) begin
            r_state <= StWr;
          end else if (w_last) begin
            r_state <= StFin;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_addr  <= r_addr + 1'b1;
            r_state <= StRd;
          end
        end
        StWr: begin
          if (i_sram_gnt) begin
            r_wcount <= r_wcount + 1'b1;
            if (w_last) begin
              r_state <= StFin;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_addr  <= r_addr + 1'b1;
              r_state <= StRd;
            end
          end
        end
        StFin:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_sram_cs    = (r_state == StRd) || (r_state == StWr);
  assign o_sram_we    = (r_state == StWr);
  assign o_sram_addr  = r_addr;
  assign o_sram_wdata = r_wdata;
  assign o_upd_busy   = (r_state != StIdle);
  assign o_upd_done   = (r_state == StFin);
  assign o_upd_wcount = r_wcount;

endmodule

// File: tb/tb_sdsp_rmw_sequencer.sv
// Bench for sdsp_rmw_sequencer: SRAM model, expected-write scoreboard and directed sweeps.
`timescale 1ns/1ps
module tb_sdsp_rmw_sequencer;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int NW = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic          v_up = 1'b0;
  logic          v_dn = 1'b0;
  logic          bist = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] wcount;
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic [DW-1:0] rdata = '0;
  logic [7:0]    pre = 8'hFF;

  sdsp_rmw_sequencer #(
    .WIDTH(3), .SYN_PER_WORD(8), .AW(AW), .N_WORDS(NW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_upd_req(req), .i_upd_base(base_in),
    .i_upd_v_up(v_up), .i_upd_v_down(v_dn), .i_upd_bist(bist),
    .o_upd_busy(busy), .o_upd_done(done), .o_upd_wcount(wcount),
    .o_sram_cs(cs), .o_sram_we(we), .o_sram_addr(addr), .o_sram_wdata(wdata),
    .i_sram_gnt(gnt), .i_sram_rdata(rdata), .i_pre_act(pre)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int t0 = 0;
  int rel;
  logic stall_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  assign rel = cyc - t0;
  // Word 0 stall: read held off in cycles 1..4, write in cycles 7..8.
  assign gnt = !(stall_en && ((rel >= 1 && rel <= 4) || rel == 7 || rel == 8));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM model with bulk preload port.
  logic [DW-1:0] mem [0:8191];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_base = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) for (int k = 0; k < NW; k++) mem[pl_base + AW'(k)] <= pl_data;
    if (cs && gnt) begin
      if (we) mem[addr] <= wdata;
      else    rdata <= mem[addr];
    end
  end

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t q[$];

  always @(negedge clk) begin
    wr_t e;
    if (!rst && cs && gnt && we) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", addr, wdata);
      end else begin
        e = q.pop_front();
        check("write_addr", longint'(addr), longint'(e.a));
        check("write_data", longint'(wdata), longint'(e.d));
      end
    end
  end

  task automatic preload(input logic [AW-1:0] b, input logic [DW-1:0] d);
    @(negedge clk);
    pl_base = b;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] b, input logic vu, input logic vd, input logic bi);
    @(negedge clk);
    base_in = b;
    v_up    = vu;
    v_dn    = vd;
    bist    = bi;
    req     = 1'b1;
    @(posedge clk);
    #1;
    t0  = cyc - 1;
    req = 1'b0;
    check("busy_after_accept", longint'(busy), 1);
  endtask

  task automatic sweep(input string tag, input logic [AW-1:0] b, input logic [DW-1:0] win,
                       input logic [DW-1:0] wexp, input logic [7:0] pm, input logic vu,
                       input logic vd, input logic bi, input int exp_done, input int exp_wc);
    int done_rel;
    wr_t e;
    preload(b, win);
    pre = pm;
    if (wexp != win) begin
      for (int k = 0; k < NW; k++) begin
        e.a = b + AW'(k);
        e.d = wexp;
        q.push_back(e);
      end
    end
    start(b, vu, vd, bi);
    done_rel = -1;
    for (int n = 0; n < 400 && done_rel < 0; n++) begin
      @(negedge clk);
      if (stall_en && ((rel >= 1 && rel <= 4) || rel == 7 || rel == 8))
        check({tag, "_stall_hold"}, longint'({cs, addr}), longint'({1'b1, b}));
      if (done) begin
        done_rel = rel;
        check({tag, "_wcount"}, longint'(wcount), longint'(exp_wc));
      end
    end
    check({tag, "_done_cycle"}, longint'(done_rel), longint'(exp_done));
    @(negedge clk);
    check({tag, "_idle_busy"}, longint'({busy, done, cs}), 0);
    check({tag, "_queue_empty"}, longint'(q.size()), 0);
    check({tag, "_mem_first"}, longint'(mem[b]), longint'(wexp));
    check({tag, "_mem_last"}, longint'(mem[b + AW'(NW - 1)]), longint'(wexp));
    q.delete();
  endtask

  initial begin
    int hit;
    wr_t e;
    repeat (3) @(negedge clk);
    check("reset_outputs", longint'({busy, done, cs, we, addr, wdata, wcount}), 0);
    rst = 1'b0;

    sweep("up",       13'h100, 32'h33333333, 32'h44444444, 8'hFF, 1, 0, 0, 97, 32);
    stall_en = 1'b1;
    sweep("stall",    13'h300, 32'h33333333, 32'h44444444, 8'hFF, 1, 0, 0, 103, 32);
    stall_en = 1'b0;
    sweep("sat_up",   13'h200, 32'h77777777, 32'h77777777, 8'hFF, 1, 0, 0, 65, 0);
    sweep("sat_dn",   13'h500, 32'h80808080, 32'h80808080, 8'hFF, 0, 1, 0, 65, 0);
    sweep("mixed",    13'h600, 32'h75757575, 32'h76767676, 8'hFF, 1, 0, 0, 97, 32);
    sweep("pre_mask", 13'h700, 32'hA2A2A2A2, 32'hA2A29191, 8'h0F, 0, 1, 0, 97, 32);
    sweep("bist",     13'h800, 32'h25252525, 32'h16161616, 8'hFF, 1, 0, 1, 97, 32);
    sweep("wrap",     13'h1FF0, 32'h11111111, 32'h22222222, 8'hFF, 1, 0, 0, 97, 32);
    check("wrap_mem_1fff", longint'(mem[13'h1FFF]), 32'h22222222);
    check("wrap_mem_000f", longint'(mem[13'h000F]), 32'h22222222);

    // Reset in cycle 20: words 0..5 written (WR at cycles 3..18), word 6 is in CAP.
    preload(13'h400, 32'h33333333);
    pre = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      e.a = 13'h400 + AW'(k);
      e.d = 32'h44444444;
      q.push_back(e);
    end
    start(13'h400, 1, 0, 0);
    hit = 0;
    for (int n = 0; n < 100 && hit == 0; n++) begin
      @(negedge clk);
      if (rel == 20) hit = 1;
    end
    check("rst_reached_cycle20", longint'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", longint'({busy, done, cs, we, addr, wdata, wcount}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_still_idle", longint'({busy, cs}), 0);
    check("rst_queue_empty", longint'(q.size()), 0);
    check("rst_mem_word5", longint'(mem[13'h405]), 32'h44444444);
    check("rst_mem_word6", longint'(mem[13'h406]), 32'h33333333);
    check("rst_mem_word31", longint'(mem[13'h41F]), 32'h33333333);
    q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdsp_rmw_sequencer.md
# sdsp_rmw_sequencer

Read-modify-write sequencer that applies SDSP weight updates to one pre-synaptic neuron's row of synapses in the synapse SRAM. On a request it sweeps N_WORDS consecutive SRAM words. For each word it reads the word, updates every synapse lane through SYN_PER_WORD instances of sdsp_update, and writes the word back only if it changed. It sits between the neuron/learning controller and the SRAM arbiter, and it yields to the arbiter through a per-access grant.

## Interface
Parameters:
- WIDTH, 3: synapse weight MSB index; each synapse is WIDTH+1 bits.
- SYN_PER_WORD, 8: synapses per SRAM word. DW = SYN_PER_WORD*(WIDTH+1) is derived, not a parameter.
- AW, 13: SRAM address width.
- N_WORDS, 32: words per sweep, range 1..2^AW.

Ports:
- CLK, in, 1: single clock, rising edge.
- RST, in, 1: asynchronous, active-high reset.
- UPD_REQ, in, 1: sweep request; sampled only in IDLE.
- UPD_BASE, in, AW: first word address; latched at accept.
- UPD_V_UP, in, 1: up-threshold flag; latched at accept.
- UPD_V_DOWN, in, 1: down-threshold flag; latched at accept.
- UPD_BIST, in, 1: BIST reference mode; latched at accept, drives SYN_BIST_REF of all lanes.
- UPD_BUSY, out, 1: high from the cycle after accept through FIN.
- UPD_DONE, out, 1: one-cycle pulse in FIN.
- UPD_WCOUNT, out, $clog2(N_WORDS+1): words written in the current/last sweep.
- SRAM_CS, out, 1: access request.
- SRAM_WE, out, 1: 1 = write.
- SRAM_ADDR, out, AW: access address.
- SRAM_WDATA, out, DW: write data.
- SRAM_GNT, in, 1: arbiter grant; an access occurs only in a cycle with SRAM_CS & SRAM_GNT.
- SRAM_RDATA, in, DW: read data, valid the cycle after a granted read.
- PRE_ACT, in, SYN_PER_WORD: per-lane SYN_PRE; valid with SRAM_RDATA.

## Operation
- Lane i uses bits [i*(WIDTH+1) +: WIDTH+1] and PRE_ACT[i]. All lanes share the latched V_UP, V_DOWN and BIST flags.
- FSM states: IDLE, RD, CAP, WR, FIN.
- IDLE: on UPD_REQ, latch base address, flags and idx=0, clear WCOUNT, then go to RD.
- RD: CS=1, WE=0, ADDR=base+idx. If GNT, go to CAP; otherwise hold with CS asserted.
- CAP: compute the new word combinationally from SRAM_RDATA and PRE_ACT, and register it into the WDATA register.
  - If new word ≠ read word, go to WR.
  - Otherwise the write is skipped: go to FIN if idx=N_WORDS-1, else increment idx and go to RD.
- WR: CS=1, WE=1, same ADDR, WDATA from the register. If GNT, increment WCOUNT, then go to FIN (last word) or to RD with idx+1. Otherwise hold.
- FIN: DONE=1, then go to IDLE. UPD_REQ is ignored in FIN and in all busy states.
- ADDR arithmetic is modulo 2^AW: base+idx wraps past 2^AW-1 to 0.
- Saturation (lane at max going up, or at 0 going down) leaves the lane unchanged. If every lane is unchanged, no write is issued.
- CS, WE, ADDR and BUSY are decoded from registered state only. CS=0 and WE=0 in IDLE, CAP and FIN.
- SRAM_WDATA holds its register value at all times.

## Timing
- Reset values: state IDLE, BUSY 0, DONE 0, CS 0, WE 0, ADDR 0, WDATA 0, WCOUNT 0, idx 0.
- Accept edge is t=0. With no stalls and all words changed:
  - Word k: RD at cycle 3k+1, CAP at 3k+2, WR at 3k+3.
  - DONE is high at cycle 3N_WORDS+1.
- Each skipped write removes 1 cycle. Each cycle with GNT low during RD/WR adds 1 cycle.
- REQ held high through FIN starts a new sweep on the first IDLE cycle. The requester must drop REQ on DONE.
- RST asserted mid-sweep: immediate return to reset values and no further SRAM access. A granted write in flight at the edge is complete; later words are untouched.

## Test plan
- Single up sweep: base=0x100, N_WORDS=32, V_UP=1, all PRE_ACT=1, SRAM all lanes 3 -> 32 writes of all lanes 4, addresses 0x100..0x11F, DONE at cycle 97, WCOUNT=32.
- Saturation/skip: lanes at 7 with V_UP=1, or lanes at 0 with V_DOWN=1 -> no writes, DONE at cycle 65, WCOUNT=0. Mixed lanes 7/5 -> only the 5-lanes go to 6.
- PRE_ACT mask 0x0F with V_DOWN=1, lanes at 2 -> lanes 0-3 become 1, lanes 4-7 stay 2; bit WIDTH of every lane preserved.
- BIST: UPD_BIST=1, lanes 2 and 5 -> 2→1 and 5→6 regardless of V_UP/V_DOWN.
- Grant stall: GNT low 4 cycles during RD and 2 cycles during WR of word 0 -> CS held, address stable, DONE delayed by 6 cycles, data unchanged from no-stall result.
- Wrap/reset: base=0x1FF0, N_WORDS=32 -> addresses 0x1FF0..0x1FFF then 0x0000..0x000F. RST at cycle 20 -> all outputs at reset values next cycle, memory beyond the last granted write unchanged.
